// File: rtl/uart_rx_buffer_pkg.sv
// Shared register map, STATUS bit layout and character constants for the
// UART receive buffer register block.
package uart_rx_buffer_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  localparam int VALID_BIT   = 8;
  localparam int EMPTY_BIT   = 16;
  localparam int FULL_BIT    = 17;
  localparam int OVF_BIT     = 18;
  localparam int LINECNT_LSB = 24;
  localparam int IRQ_EN_BIT  = 0;
  localparam int FLUSH_BIT   = 1;

  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL
  } reg_sel_e;

  function automatic logic [31:0] status_word(input logic [8:0] count,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] line_cnt);
    logic [31:0] w;
    w                      = '0;
    w[8:0]                 = count;
    w[EMPTY_BIT]           = empty;
    w[FULL_BIT]            = full;
    w[OVF_BIT]             = ovf;
    w[LINECNT_LSB +: 8]    = line_cnt;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_core.sv
// Byte FIFO with push/pop/flush; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module uart_rx_fifo_core #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full_o    = (count == CNT_W'(DEPTH));
  assign empty_o   = (count == '0);
  assign pop_ok_o  = pop_i & ~empty_o;
  assign push_ok_o = push_i & ~flush_i & (~full_o | pop_ok_o);
  assign head_o    = mem[rd_ptr];
  assign count_o   = count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_o) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_o)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_o, pop_ok_o})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_buffer_regs.sv
// Bus-mapped UART receive buffer: DATA/STATUS/CTRL registers, LF line counter
// and line-ready interrupt (present only when UART_RX_BUFFER_IRQ_EN is defined).
module uart_rx_buffer_regs
  import uart_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  irq_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] DATA_ADDR   = ADDR_WIDTH'(BASE_ADDR + DATA_OFS);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(BASE_ADDR + STATUS_OFS);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(BASE_ADDR + CTRL_OFS);

  reg_sel_e         sel;
  logic             rx_valid_q;
  logic             data_rd_q;
  logic             data_rd;
  logic             push_req;
  logic             pop_req;
  logic             flush;
  logic             status_wr;
  logic             ctrl_wr;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf;
  logic [7:0]       line_cnt;
  logic             lf_in;
  logic             lf_out;
  logic             line_dec_ok;
  logic             irq_en;
  logic [31:0]      pop_word;
  logic             unused_data_bits;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if      (address_i == DATA_ADDR)   sel = SEL_DATA;
    else if (address_i == STATUS_ADDR) sel = SEL_STATUS;
    else if (address_i == CTRL_ADDR)   sel = SEL_CTRL;
  end

  // Push fires on the rising edge of rx_valid; pop on the first cycle of a DATA read.
  assign data_rd   = (sel == SEL_DATA) && !we_i;
  assign push_req  = rx_valid_i && !rx_valid_q;
  assign pop_req   = data_rd && !data_rd_q;
  assign status_wr = (sel == SEL_STATUS) && we_i;
  assign ctrl_wr   = (sel == SEL_CTRL) && we_i;
  assign flush     = ctrl_wr && data_i[FLUSH_BIT];
  assign unused_data_bits = ^data_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_valid_q <= 1'b0;
      data_rd_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_i;
      data_rd_q  <= data_rd;
    end
  end

  uart_rx_fifo_core #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .push_i    (push_req),
    .pop_i     (pop_req),
    .flush_i   (flush),
    .wdata_i   (rx_data_i),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok)
  );

  // A rejected push overflows only when it was not squashed by a flush.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                 ovf <= 1'b0;
    else if (push_req && !flush && !push_ok)       ovf <= 1'b1;
    else if (status_wr && data_i[OVF_BIT])         ovf <= 1'b0;
  end

  assign lf_in  = push_ok && (rx_data_i == ASCII_LF);
  assign lf_out = pop_ok && (head == ASCII_LF);
  // Once pinned at 255 the true line count is unknown; only trust a decrement
  // when the buffer could actually hold that many newlines.
  assign line_dec_ok = (line_cnt != 8'd0) &&
                       ((line_cnt != 8'hFF) || ({1'b0, line_cnt} <= 9'(count)));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      line_cnt <= 8'd0;
    end else if (flush) begin
      line_cnt <= 8'd0;
    end else if (lf_in && !lf_out) begin
      if (line_cnt != 8'hFF) line_cnt <= line_cnt + 8'd1;
    end else if (lf_out && !lf_in && line_dec_ok) begin
      line_cnt <= line_cnt - 8'd1;
    end
  end

`ifdef UART_RX_BUFFER_IRQ_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= data_i[IRQ_EN_BIT];
      irq_o <= irq_en && (line_cnt != 8'd0);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  always_comb begin
    pop_word            = '0;
    pop_word[7:0]       = head;
    pop_word[VALID_BIT] = 1'b1;
  end

  // A held DATA address keeps the last popped word rather than re-reading.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_o <= '0;
    end else if (!we_i) begin
      case (sel)
        SEL_DATA:   if (pop_req) data_o <= pop_ok ? DATA_WIDTH'(pop_word) : '0;
        SEL_STATUS: data_o <= DATA_WIDTH'(status_word(9'(count), empty, full, ovf, line_cnt));
        SEL_CTRL:   data_o <= DATA_WIDTH'({31'b0, irq_en});
        default:    data_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer_regs.sv
// Scoreboard bench for uart_rx_buffer_regs: stimulus queues expected bus/irq
// values, a monitor pops and compares them on the cycle they become visible.
module tb_uart_rx_buffer_regs;

  localparam logic [31:0] IDLE_ADDR   = 32'h100;
  localparam logic [31:0] DATA_ADDR   = 32'h0;
  localparam logic [31:0] STATUS_ADDR = 32'h4;
  localparam logic [31:0] CTRL_ADDR   = 32'h8;
`ifdef UART_RX_BUFFER_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk_i      = 1'b0;
  logic        reset_ni   = 1'b0;
  logic [7:0]  rx_data_i  = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [31:0] address_i  = IDLE_ADDR;
  logic        we_i       = 1'b0;
  logic [31:0] data_i     = 32'h0;
  logic [31:0] data_o;
  logic        irq_o;

  exp_t sb[$];
  logic rd_tag    = 1'b0;
  logic mon_armed = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  uart_rx_buffer_regs #(
    .DEPTH      (16),
    .BASE_ADDR  (32'h0),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .address_i  (address_i),
    .we_i       (we_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Monitor: an expectation queued before edge N is compared after edge N.
  always @(posedge clk_i) mon_armed <= rd_tag;

  always @(negedge clk_i) begin
    if (mon_armed) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_irq) check(e.name, {31'b0, irq_o}, e.exp);
        else          check(e.name, data_o, e.exp);
      end
    end
  end

  task automatic expect_cycle(input bit is_irq, input logic [31:0] exp, input string name);
    exp_t e;
    e.is_irq = is_irq;
    e.exp    = exp;
    e.name   = name;
    sb.push_back(e);
    rd_tag = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk_i);
    address_i = addr;
    we_i      = 1'b0;
    expect_cycle(1'b0, exp, name);
    @(negedge clk_i);
    rd_tag    = 1'b0;
    address_i = IDLE_ADDR;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    address_i = addr;
    we_i      = 1'b1;
    data_i    = data;
    @(negedge clk_i);
    we_i      = 1'b0;
    address_i = IDLE_ADDR;
    data_i    = 32'h0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic probe_irq(input logic exp, input string name);
    @(negedge clk_i);
    expect_cycle(1'b1, {31'b0, exp}, name);
    @(negedge clk_i);
    rd_tag = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    check("reset_data_o", data_o, 32'h0);
    check("reset_irq_o", {31'b0, irq_o}, 32'h0);
    #20 reset_ni = 1'b1;
    bus_read(STATUS_ADDR, 32'h0001_0000, "reset_status");
    bus_read(CTRL_ADDR,   32'h0,         "reset_ctrl");

    // Basic "AB\n"
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h0A);
    bus_read(STATUS_ADDR, 32'h0100_0003, "basic_status");
    bus_read(DATA_ADDR,   32'h141,       "basic_pop_a");
    bus_read(DATA_ADDR,   32'h142,       "basic_pop_b");
    bus_read(DATA_ADDR,   32'h10A,       "basic_pop_lf");
    bus_read(DATA_ADDR,   32'h000,       "basic_pop_empty");
    bus_read(STATUS_ADDR, 32'h0001_0000, "basic_status_empty");

    // rx_valid held high for 20 cycles pushes once
    @(negedge clk_i);
    rx_data_i  = 8'h55;
    rx_valid_i = 1'b1;
    repeat (20) @(negedge clk_i);
    rx_valid_i = 1'b0;
    bus_read(STATUS_ADDR, 32'h0000_0001, "level_status");
    bus_read(DATA_ADDR,   32'h155,       "level_pop");

    // Overflow: 17 pushes into 16 entries, 0x0A among them
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_read(STATUS_ADDR, 32'h0106_0010, "ovf_status");
    bus_write(STATUS_ADDR, 32'h0004_0000);
    bus_read(STATUS_ADDR, 32'h0102_0010, "ovf_cleared_status");
    for (int i = 0; i < 16; i++) bus_read(DATA_ADDR, 32'h100 + 32'(i), "ovf_pop");
    bus_read(STATUS_ADDR, 32'h0001_0000, "ovf_drained_status");

    // Push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    @(negedge clk_i);
    rx_data_i  = 8'h7E;
    rx_valid_i = 1'b1;
    address_i  = DATA_ADDR;
    expect_cycle(1'b0, 32'h120, "full_pushpop_pop");
    @(negedge clk_i);
    rd_tag     = 1'b0;
    rx_valid_i = 1'b0;
    address_i  = IDLE_ADDR;
    bus_read(STATUS_ADDR, 32'h0002_0010, "full_pushpop_status");
    for (int i = 1; i < 16; i++) bus_read(DATA_ADDR, 32'h120 + 32'(i), "full_pushpop_drain");
    bus_read(DATA_ADDR,   32'h17E,       "full_pushpop_last");
    bus_read(STATUS_ADDR, 32'h0001_0000, "full_pushpop_empty");

    // Line-ready interrupt
    bus_write(CTRL_ADDR, 32'h1);
    bus_read(CTRL_ADDR, {31'b0, IRQ_BUILT}, "ctrl_irq_en");
    push_byte(8'h78);
    @(negedge clk_i);
    rx_data_i  = 8'h0A;
    rx_valid_i = 1'b1;
    expect_cycle(1'b1, 32'h0, "irq_before_lf");
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    expect_cycle(1'b1, {31'b0, IRQ_BUILT}, "irq_rise");
    @(negedge clk_i);
    rd_tag = 1'b0;
    bus_read(DATA_ADDR, 32'h178, "irq_pop_x");
    bus_read(DATA_ADDR, 32'h10A, "irq_pop_lf");
    probe_irq(1'b0, "irq_fall_after_pop");

    // Flush with two lines buffered
    push_byte(8'h0A);
    push_byte(8'h0A);
    probe_irq(IRQ_BUILT, "irq_two_lines");
    bus_read(STATUS_ADDR, 32'h0200_0002, "two_lines_status");
    @(negedge clk_i);
    address_i = CTRL_ADDR;
    we_i      = 1'b1;
    data_i    = 32'h3;
    expect_cycle(1'b1, {31'b0, IRQ_BUILT}, "irq_at_flush");
    @(negedge clk_i);
    we_i      = 1'b0;
    address_i = IDLE_ADDR;
    data_i    = 32'h0;
    expect_cycle(1'b1, 32'h0, "irq_after_flush");
    @(negedge clk_i);
    rd_tag = 1'b0;
    bus_read(STATUS_ADDR, 32'h0001_0000, "flush_status");
    bus_read(CTRL_ADDR, {31'b0, IRQ_BUILT}, "flush_reads_zero");

    // Held DATA address pops once, then reset mid-operation
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    push_byte(8'h64);
    push_byte(8'h0A);
    probe_irq(IRQ_BUILT, "irq_five_bytes");
    @(negedge clk_i);
    address_i = DATA_ADDR;
    expect_cycle(1'b0, 32'h161, "held_pop");
    @(negedge clk_i);
    rd_tag = 1'b0;
    repeat (2) @(negedge clk_i);
    address_i = IDLE_ADDR;
    bus_read(STATUS_ADDR, 32'h0100_0004, "held_status");
    @(negedge clk_i);
    address_i = DATA_ADDR;
    expect_cycle(1'b0, 32'h162, "pre_reset_pop");
    @(negedge clk_i);
    rd_tag = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    check("async_reset_data_o", data_o, 32'h0);
    check("async_reset_irq_o", {31'b0, irq_o}, 32'h0);
    address_i = IDLE_ADDR;
    @(negedge clk_i);
    #2 reset_ni = 1'b1;
    bus_read(STATUS_ADDR, 32'h0001_0000, "post_reset_status");
    bus_read(CTRL_ADDR,   32'h0,         "post_reset_ctrl");

    repeat (3) @(negedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
